// File: rtl/decode_queue.sv
// Decode stage: MIPS instructions are decoded on entry and held in a circular queue
// of DEPTH entries, with sticky halt, synchronous flush and optional LL/SC support.
module decode_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter bit          ATOMIC_EN = 1'b1
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [31:0]                  in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [31:0]                  out_pc,
  output logic [3:0]                   aluop,
  output logic                         wen,
  output logic                         regdst,
  output logic                         alusrc,
  output logic                         extop,
  output logic                         memtoreg,
  output logic                         dren,
  output logic                         dwen,
  output logic                         brnch_eq,
  output logic                         brnch_ne,
  output logic                         jmp,
  output logic                         jr,
  output logic                         jal,
  output logic                         shift,
  output logic                         lui,
  output logic                         atomic,
  output logic                         halt,
  output logic                         illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [3:0] AluSll  = 4'd0;
  localparam logic [3:0] AluSrl  = 4'd1;
  localparam logic [3:0] AluAdd  = 4'd2;
  localparam logic [3:0] AluSub  = 4'd3;
  localparam logic [3:0] AluAnd  = 4'd4;
  localparam logic [3:0] AluOr   = 4'd5;
  localparam logic [3:0] AluXor  = 4'd6;
  localparam logic [3:0] AluNor  = 4'd7;
  localparam logic [3:0] AluSlt  = 4'd8;
  localparam logic [3:0] AluSltu = 4'd9;

  typedef struct packed {
    logic [3:0] aluop;
    logic wen, regdst, alusrc, extop, memtoreg, dren, dwen;
    logic brnch_eq, brnch_ne, jmp, jr, jal, shift, lui, atomic, halt, illegal;
  } ctl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    ctl_t        ctl;
  } entry_t;

  typedef enum logic {StRun, StHalted} state_e;

  entry_t          mem [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  state_e          state_q;
  ctl_t            dec;
  ctl_t            head_ctl;
  logic            push, pop;

  always_comb begin
    dec = '0;
    if (in_instr != 32'h0) begin
      case (in_instr[31:26])
        6'h00: begin
          dec.wen    = 1'b1;
          dec.regdst = 1'b1;
          case (in_instr[5:0])
            6'h00: begin dec.shift = 1'b1; dec.aluop = AluSll; end
            6'h02: begin dec.shift = 1'b1; dec.aluop = AluSrl; end
            6'h08: begin dec.jr = 1'b1; dec.wen = 1'b0; end
            6'h21: dec.aluop = AluAdd;
            6'h23: dec.aluop = AluSub;
            6'h24: dec.aluop = AluAnd;
            6'h25: dec.aluop = AluOr;
            6'h26: dec.aluop = AluXor;
            6'h27: dec.aluop = AluNor;
            6'h2a: dec.aluop = AluSlt;
            6'h2b: dec.aluop = AluSltu;
            default: begin dec = '0; dec.illegal = 1'b1; end
          endcase
        end
        6'h02: dec.jmp = 1'b1;
        6'h03: begin dec.jal = 1'b1; dec.wen = 1'b1; end
        6'h04: begin dec.brnch_eq = 1'b1; dec.aluop = AluSub; end
        6'h05: begin dec.brnch_ne = 1'b1; dec.aluop = AluSub; end
        6'h09, 6'h0a, 6'h0b: begin
          dec.wen    = 1'b1;
          dec.alusrc = 1'b1;
          dec.extop  = 1'b1;
          dec.aluop  = (in_instr[27:26] == 2'b01) ? AluAdd :
                       (in_instr[27:26] == 2'b10) ? AluSlt : AluSltu;
        end
        6'h0c, 6'h0d, 6'h0e: begin
          dec.wen    = 1'b1;
          dec.alusrc = 1'b1;
          dec.aluop  = (in_instr[27:26] == 2'b00) ? AluAnd :
                       (in_instr[27:26] == 2'b01) ? AluOr : AluXor;
        end
        6'h0f: begin
          dec.wen = 1'b1; dec.alusrc = 1'b1; dec.extop = 1'b1; dec.lui = 1'b1;
          dec.aluop = AluAdd;
        end
        6'h23: begin
          dec.wen = 1'b1; dec.alusrc = 1'b1; dec.extop = 1'b1;
          dec.memtoreg = 1'b1; dec.dren = 1'b1; dec.aluop = AluAdd;
        end
        6'h2b: begin
          dec.alusrc = 1'b1; dec.extop = 1'b1; dec.dwen = 1'b1; dec.aluop = AluAdd;
        end
        6'h30: begin
          if (ATOMIC_EN) begin
            dec.wen = 1'b1; dec.alusrc = 1'b1; dec.extop = 1'b1; dec.memtoreg = 1'b1;
            dec.dren = 1'b1; dec.atomic = 1'b1; dec.aluop = AluAdd;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        6'h38: begin
          if (ATOMIC_EN) begin
            dec.wen = 1'b1; dec.alusrc = 1'b1; dec.extop = 1'b1; dec.memtoreg = 1'b1;
            dec.dwen = 1'b1; dec.atomic = 1'b1; dec.aluop = AluAdd;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        6'h3f: dec.halt = 1'b1;
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  // Readiness depends only on registered state, never on out_ready.
  assign in_ready  = (count_q != CntW'(DEPTH)) && (state_q == StRun);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge CLK) begin
    if (!nRST || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StRun;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntW'(1);
      else if (pop && !push) count_q <= count_q - CntW'(1);
      if (push && dec.halt) state_q <= StHalted;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= '{instr: in_instr, pc: in_pc, ctl: dec};
  end

  assign head_ctl  = out_valid ? mem[rd_ptr_q].ctl : '0;
  assign out_instr = out_valid ? mem[rd_ptr_q].instr : '0;
  assign out_pc    = out_valid ? mem[rd_ptr_q].pc : '0;
  assign count     = count_q;

  assign aluop    = head_ctl.aluop;
  assign wen      = head_ctl.wen;
  assign regdst   = head_ctl.regdst;
  assign alusrc   = head_ctl.alusrc;
  assign extop    = head_ctl.extop;
  assign memtoreg = head_ctl.memtoreg;
  assign dren     = head_ctl.dren;
  assign dwen     = head_ctl.dwen;
  assign brnch_eq = head_ctl.brnch_eq;
  assign brnch_ne = head_ctl.brnch_ne;
  assign jmp      = head_ctl.jmp;
  assign jr       = head_ctl.jr;
  assign jal      = head_ctl.jal;
  assign shift    = head_ctl.shift;
  assign lui      = head_ctl.lui;
  assign atomic   = head_ctl.atomic;
  assign halt     = head_ctl.halt;
  assign illegal  = head_ctl.illegal;

endmodule
